lsu: RTL
========

LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum WAIT cycles before a load is aborted.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-004 SHALL have port req_valid, input, 1: the pipeline presents an access.
REQ-005 SHALL have port req_ready, output, 1: the block accepts an access.
REQ-006 SHALL have port mem_wen, input, 4: 0 = load, 1 = SB, 3 = SH, F = SW.
REQ-007 SHALL have port ld_sel, input, 3: 0 = LB, 1 = LH, 2 = LW, 3 = LBU, 4 = LHU.
REQ-008 SHALL have port addr, input, 32: byte address (ALU result).
REQ-009 SHALL have port wdata, input, 32: store data (rs2).
REQ-010 SHALL have port resp_valid, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port rdata, output, 32: extended load result.
REQ-012 SHALL have port err, output, 1: qualifies resp_valid; set on misalignment or timeout.
REQ-013 SHALL have port stall, output, 1: hold the pipeline.
REQ-014 SHALL have port dmem_req, output, 1: memory request.
REQ-015 SHALL have port dmem_gnt, input, 1: memory accepts the request.
REQ-016 SHALL have port dmem_addr, output, 32: word address, {addr[31:2], 2'b00}.
REQ-017 SHALL have port dmem_we, output, 4: byte write enables; 0 for loads.
REQ-018 SHALL have port dmem_wdata, output, 32: lane-replicated store data.
REQ-019 SHALL have port dmem_rvalid, input, 1: read data valid.
REQ-020 SHALL have port dmem_rdata, input, 32: read word.

Function
REQ-021 SHALL implement FSM states IDLE, REQ, WAIT, RESP.
REQ-022 SHALL drive req_ready=1 only in IDLE.
- Accept = req_valid && req_ready.
- On accept, capture mem_wen, ld_sel, addr, wdata.
REQ-023 SHALL decode the captured fields as follows:
- mem_wen values other than 0, 1 or 3 are treated as F.
- ld_sel values 5-7 are treated as LW.
REQ-024 SHALL flag misalignment when any of the following holds:
- SH/LH/LHU with addr[0]=1;
- SW/LW with addr[1:0]!=0.
- A misaligned access goes to RESP with err=1 and rdata=0, and SHALL issue no dmem_req.
REQ-025 SHALL transition as follows:
- IDLE -> REQ on an aligned accept.
- In REQ, dmem_req=1 with dmem_addr, dmem_we and dmem_wdata held stable until dmem_gnt.
- REQ + gnt -> RESP for a store.
- REQ + gnt -> WAIT for a load.
REQ-026 SHALL form store enables and data as follows:
- dmem_we = base mask << addr[1:0], where base mask is 1, 3 or F.
- dmem_wdata = {4{wdata[7:0]}} for SB, {2{wdata[15:0]}} for SH, wdata for SW.
REQ-027 SHALL, in WAIT, on dmem_rvalid:
- select the byte/halfword lane by captured addr[1:0];
- sign-extend for LB/LH, zero-extend for LBU/LHU;
- register the result into rdata and go to RESP.
REQ-028 SHALL count WAIT cycles.
- If the count reaches TIMEOUT without rvalid, go to RESP with err=1 and rdata=0.
- The counter clears on entry to WAIT.
REQ-029 SHALL hold resp_valid=1 for exactly one cycle in RESP, then return to IDLE.
- rdata and err SHALL hold until the next RESP.
REQ-030 SHALL drive stall=1 whenever state != IDLE.
REQ-031 SHALL ignore dmem_rvalid outside WAIT, and dmem_gnt outside REQ.
REQ-032 SHALL meet these latencies, counting the accept cycle as cycle 0:
- store with immediate gnt: dmem_req at cycle 1, resp_valid at cycle 2;
- load with rvalid at cycle k: resp_valid at cycle k+1;
- misaligned access: resp_valid at cycle 1.
REQ-033 SHALL, on rvalid in the same cycle the timeout is reached, take the data (err=0).

Reset
REQ-034 SHALL, on rst_n=0 at a clock edge, reset as follows:
- state = IDLE; counter = 0;
- resp_valid, err, dmem_req, stall = 0;
- rdata, dmem_addr, dmem_we, dmem_wdata = 0.
REQ-035 SHALL abandon any in-flight access on reset mid-operation.
- A late dmem_rvalid after reset SHALL produce no resp_valid.
REQ-036 SHALL drive req_ready=1 in the first cycle after reset deasserts.

Verification
REQ-037 SB addr=0x1002 wdata=0xAB -> dmem_we=4'b0100, dmem_wdata=0xABABABAB, dmem_addr=0x1000, resp_valid one cycle after gnt, err=0.
REQ-038 LB addr=0x3 with dmem_rdata=0x80FF_FF7F, then LBU addr=0x3 with the same data -> rdata=0xFFFFFF80, then rdata=0x00000080.
REQ-039 LH addr=0x2 with rdata word 0x8001_1234 -> rdata=0xFFFF8001; gnt delayed 3 cycles -> dmem_req and dmem_addr stable for the whole delay, stall=1 throughout.
REQ-040 SW addr=0x6 -> no dmem_req, resp_valid at cycle 1 with err=1, rdata=0.
REQ-041 LW with TIMEOUT=4 and no rvalid -> resp_valid after 4 WAIT cycles with err=1; a later rvalid is ignored.
REQ-042 Reset asserted in WAIT, then rvalid pulsed -> no resp_valid, all outputs 0, req_ready=1 after reset release.

Source files
------------

// File: rtl/lsu.sv
// Load/store unit: a single outstanding access, word-aligned memory port, byte/halfword lane handling.
// Misaligned accesses and load timeouts complete with err=1 and rdata=0.
module lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  mem_wen,
  input  logic [2:0]  ld_sel,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  output logic [31:0] rdata,
  output logic        err,
  output logic        stall,
  output logic        dmem_req,
  input  logic        dmem_gnt,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_we,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [2:0] LD_B  = 3'd0;
  localparam logic [2:0] LD_H  = 3'd1;
  localparam logic [2:0] LD_W  = 3'd2;
  localparam logic [2:0] LD_BU = 3'd3;
  localparam logic [2:0] LD_HU = 3'd4;

  // Counter only needs to reach TIMEOUT-1: the final WAIT cycle decides abort.
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  function automatic logic [3:0] base_mask(input logic [3:0] wen);
    case (wen)
      4'h0:    return 4'h0;
      4'h1:    return 4'h1;
      4'h3:    return 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [2:0] norm_sel(input logic [2:0] s);
    return (s > LD_HU) ? LD_W : s;
  endfunction

  function automatic logic misaligned(input logic [3:0] mask, input logic [2:0] sel,
                                      input logic [1:0] off);
    logic half, word;
    half = (mask == 4'h3) || ((mask == 4'h0) && ((sel == LD_H) || (sel == LD_HU)));
    word = (mask == 4'hF) || ((mask == 4'h0) && (sel == LD_W));
    return (half && off[0]) || (word && (off != 2'b00));
  endfunction

  function automatic logic [31:0] store_data(input logic [3:0] mask, input logic [31:0] wd);
    case (mask)
      4'h1:    return {4{wd[7:0]}};
      4'h3:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] sel, input logic [1:0] off,
                                           input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (sel)
      LD_B:    return {{24{b[7]}}, b};
      LD_H:    return {{16{h[15]}}, h};
      LD_BU:   return {24'b0, b};
      LD_HU:   return {16'b0, h};
      default: return word;
    endcase
  endfunction

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [1:0]       off_q;
  logic [2:0]       sel_q;
  logic             load_q;
  logic [31:0]      daddr_q;
  logic [3:0]       we_q;
  logic [31:0]      wdata_q;

  logic             accept;
  logic [3:0]       mask_in;
  logic [2:0]       sel_in;
  logic             mis_in;

  assign accept  = req_valid && (state_q == IDLE);
  assign mask_in = base_mask(mem_wen);
  assign sel_in  = norm_sel(ld_sel);
  assign mis_in  = misaligned(mask_in, sel_in, addr[1:0]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (mis_in) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (dmem_gnt) begin
          if (load_q) begin
            state_d = WAIT;
            cnt_d   = '0;
          end else begin
            state_d = RESP;
            err_d   = 1'b0;
            rdata_d = 32'h0;
          end
        end
      end
      WAIT: begin
        // Data arriving on the last allowed cycle still wins over the abort.
        if (dmem_rvalid) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = load_ext(sel_q, off_q, dmem_rdata);
        end else if (cnt_q == CNT_LAST) begin
          state_d = RESP;
          err_d   = 1'b1;
          rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      off_q   <= 2'b00;
      sel_q   <= LD_B;
      load_q  <= 1'b0;
      daddr_q <= 32'h0;
      we_q    <= 4'h0;
      wdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        off_q   <= addr[1:0];
        sel_q   <= sel_in;
        load_q  <= (mask_in == 4'h0);
        daddr_q <= {addr[31:2], 2'b00};
        we_q    <= mask_in << addr[1:0];
        wdata_q <= store_data(mask_in, wdata);
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign stall      = (state_q != IDLE);
  assign dmem_req   = (state_q == REQ);
  assign resp_valid = (state_q == RESP);
  assign rdata      = rdata_q;
  assign err        = err_q;
  assign dmem_addr  = daddr_q;
  assign dmem_we    = we_q;
  assign dmem_wdata = wdata_q;

endmodule
